// File: rtl/usb_crc_pkg.sv
// Shared types and CRC constants for the USB transmit CRC encoder.
package usb_crc_pkg;

    typedef enum logic {
        CRC_TOKEN = 1'b0,
        CRC_DATA  = 1'b1
    } crc_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } state_t;

    localparam logic [4:0]  CRC5_POLY      = 5'h05;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
    localparam int          TOKEN_BITS     = 11;

endpackage

// File: rtl/usb_crc_lfsr.sv
// Serial MSB-feedback CRC register: preset to all ones, shifts one bit per enable.
module usb_crc_lfsr #(
    parameter int           W    = 5,
    parameter logic [W-1:0] POLY = '0
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         init,
    input  logic         en,
    input  logic         bit_in,
    output logic [W-1:0] crc
);

    logic [W-1:0] r_crc;
    logic         w_fb;

    assign w_fb = r_crc[W-1] ^ bit_in;
    assign crc  = r_crc;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_crc <= '1;
        end else if (init) begin
            r_crc <= '1;
        end else if (en) begin
            r_crc <= {r_crc[W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
        end
    end

endmodule

// File: rtl/usb_crc_tx_encoder.sv
// Handshaked USB CRC5 (token) / CRC16 (data) generator and LSB-first serialiser.
// Define USB_CRC_SELFCHECK_EN to add the crc_err shadow-residual checker output.
module usb_crc_tx_encoder
    import usb_crc_pkg::*;
#(
    parameter int MAX_PAYLOAD_BITS = 512,
    parameter int LEN_W            = 10
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_mode,
    input  logic [LEN_W-1:0]            in_len,
    input  logic [MAX_PAYLOAD_BITS-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_bit,
    output logic                        out_last,
`ifdef USB_CRC_SELFCHECK_EN
    output logic                        crc_err,
`endif
    output logic                        busy
);

    localparam int IDX_W = (MAX_PAYLOAD_BITS > 1) ? $clog2(MAX_PAYLOAD_BITS) : 1;

    state_t                      r_state;
    crc_mode_t                   r_mode;
    logic [MAX_PAYLOAD_BITS-1:0] r_data;
    logic [LEN_W-1:0]            r_len;
    logic [LEN_W-1:0]            r_idx;
    logic [3:0]                  r_crc_cnt;
    logic                        r_in_ready;
    logic                        r_out_valid;
    logic                        r_busy;

    logic                        w_accept;
    logic [LEN_W-1:0]            w_len_eff;
    logic                        w_pay_hs;
    logic                        w_pay_bit;
    logic                        w_crc_bit;
    logic [3:0]                  w_crc_last_cnt;
    logic [4:0]                  w_crc5;
    logic [15:0]                 w_crc16;

    assign w_accept  = in_valid && r_in_ready;
    assign w_len_eff = (in_mode == 1'b0)                    ? LEN_W'(TOKEN_BITS) :
                       (in_len > LEN_W'(MAX_PAYLOAD_BITS)) ? LEN_W'(MAX_PAYLOAD_BITS) : in_len;
    assign w_pay_hs  = (r_state == DATA) && out_ready;
    assign w_pay_bit = r_data[r_idx[IDX_W-1:0]];

    // The CRC field goes out MSB of the remainder first, inverted.
    assign w_crc_last_cnt = (r_mode == CRC_DATA) ? 4'd15 : 4'd4;
    assign w_crc_bit      = (r_mode == CRC_DATA) ? ~w_crc16[~r_crc_cnt]
                                                 : ~w_crc5[3'd4 - r_crc_cnt[2:0]];

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_bit   = (r_state == DATA) ? w_pay_bit :
                       (r_state == CRC)  ? w_crc_bit : 1'b0;
    assign out_last  = (r_state == CRC) && (r_crc_cnt == w_crc_last_cnt);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data <= in_data;
            r_mode <= crc_mode_t'(in_mode);
            r_len  <= w_len_eff;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_crc_cnt   <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_idx       <= '0;
                        r_crc_cnt   <= '0;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= (w_len_eff == '0) ? CRC : DATA;
                    end
                end
                DATA: begin
                    if (out_ready) begin
                        if (r_idx == r_len - LEN_W'(1)) begin
                            r_state <= CRC;
                        end else begin
                            r_idx <= r_idx + LEN_W'(1);
                        end
                    end
                end
                CRC: begin
                    if (out_ready) begin
                        if (r_crc_cnt == w_crc_last_cnt) begin
                            r_state     <= IDLE;
                            r_in_ready  <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                        end else begin
                            r_crc_cnt <= r_crc_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Both remainders run side by side; r_mode picks the one that is emitted.
    usb_crc_lfsr #(.W(16), .POLY(CRC16_POLY)) u_crc16 (
        .clk    (clk),
        .rst_b  (rst_b),
        .init   (w_accept),
        .en     (w_pay_hs),
        .bit_in (w_pay_bit),
        .crc    (w_crc16)
    );

    usb_crc_lfsr #(.W(5), .POLY(CRC5_POLY)) u_crc5 (
        .clk    (clk),
        .rst_b  (rst_b),
        .init   (w_accept),
        .en     (w_pay_hs),
        .bit_in (w_pay_bit),
        .crc    (w_crc5)
    );

`ifdef USB_CRC_SELFCHECK_EN
    logic        w_out_hs;
    logic [4:0]  w_sh5;
    logic [15:0] w_sh16;
    logic        r_chk_pend;

    assign w_out_hs = r_out_valid && out_ready;

    usb_crc_lfsr #(.W(16), .POLY(CRC16_POLY)) u_shadow16 (
        .clk    (clk),
        .rst_b  (rst_b),
        .init   (w_accept),
        .en     (w_out_hs),
        .bit_in (out_bit),
        .crc    (w_sh16)
    );

    usb_crc_lfsr #(.W(5), .POLY(CRC5_POLY)) u_shadow5 (
        .clk    (clk),
        .rst_b  (rst_b),
        .init   (w_accept),
        .en     (w_out_hs),
        .bit_in (out_bit),
        .crc    (w_sh5)
    );

    // Residual is only meaningful once the last CRC bit has been shifted in.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_chk_pend <= 1'b0;
        end else begin
            r_chk_pend <= w_out_hs && out_last;
        end
    end

    assign crc_err = r_chk_pend && ((r_mode == CRC_DATA) ? (w_sh16 != CRC16_RESIDUAL)
                                                         : (w_sh5 != CRC5_RESIDUAL));
`endif

endmodule

// File: tb/tb_usb_crc_tx_encoder.sv
// Directed + randomized bench for usb_crc_tx_encoder against a bit-stream reference model.
module tb_usb_crc_tx_encoder;

    localparam int MAXB = 512;
    localparam int LW   = 10;
    localparam int SW   = MAXB + 16;

    logic            clk       = 1'b0;
    logic            rst_b     = 1'b0;
    logic            in_valid  = 1'b0;
    logic            in_mode   = 1'b0;
    logic            out_ready = 1'b0;
    logic [LW-1:0]   in_len    = '0;
    logic [MAXB-1:0] in_data   = '0;
    logic            in_ready, out_valid, out_bit, out_last, busy;
`ifdef USB_CRC_SELFCHECK_EN
    logic            crc_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    usb_crc_tx_encoder #(.MAX_PAYLOAD_BITS(MAXB), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_len    (in_len),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last),
`ifdef USB_CRC_SELFCHECK_EN
        .crc_err   (crc_err),
`endif
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic bitat(input logic [SW-1:0] v, input int i);
        return ((v >> i) & SW'(1)) != '0;
    endfunction

    // One step of the USB CRC rule: f = msb ^ bit; crc = (crc << 1) ^ (f ? poly : 0).
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b, input int w);
        logic [15:0] poly;
        logic [15:0] mask;
        logic        f;
        poly = (w == 16) ? 16'h8005 : 16'h0005;
        mask = (w == 16) ? 16'hFFFF : 16'h001F;
        f    = (((crc >> (w - 1)) & 16'h0001) != 16'h0000) ^ b;
        return ((crc << 1) ^ (f ? poly : 16'h0000)) & mask;
    endfunction

    function automatic void model(input logic m, input int len, input logic [MAXB-1:0] d,
                                  output logic [SW-1:0] bits, output int n);
        int          L;
        int          w;
        logic [15:0] crc;
        logic        b;
        L    = m ? ((len > MAXB) ? MAXB : len) : 11;
        w    = m ? 16 : 5;
        crc  = m ? 16'hFFFF : 16'h001F;
        bits = '0;
        n    = 0;
        for (int i = 0; i < L; i++) begin
            b    = bitat(SW'(d), i);
            bits = bits | (SW'(b) << n);
            crc  = crc_step(crc, b, w);
            n++;
        end
        for (int k = 0; k < w; k++) begin
            b    = ~(((crc >> (w - 1 - k)) & 16'h0001) != 16'h0000);
            bits = bits | (SW'(b) << n);
            n++;
        end
    endfunction

    function automatic logic [15:0] resid(input logic [SW-1:0] bits, input int n, input int w);
        logic [15:0] crc;
        crc = (w == 16) ? 16'hFFFF : 16'h001F;
        for (int i = 0; i < n; i++) crc = crc_step(crc, bitat(bits, i), w);
        return crc;
    endfunction

    function automatic logic [MAXB-1:0] rand_data();
        logic [MAXB-1:0] d;
        d = '0;
        for (int i = 0; i < MAXB / 32; i++) d = (d << 32) | MAXB'($urandom);
        return d;
    endfunction

    task automatic accept(input string tag, input logic m, input int len, input logic [MAXB-1:0] d);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_len   = LW'(len);
        in_data  = d;
        while (!in_ready && waited < 2000) begin
            @(posedge clk); #1;
            waited++;
        end
        check({tag, "_in_ready"}, SW'(in_ready), SW'(1));
        @(posedge clk); #1;
        check({tag, "_accept"}, SW'({in_ready, busy, out_valid}), SW'(3'b011));
    endtask

    task automatic collect(input int thr, output logic [SW-1:0] obs, output int n, output int last_pos,
                           output logic dropped, output logic early, output logic tmo);
        logic hs, b, l;
        obs = '0; n = 0; last_pos = -1; dropped = 1'b0; early = 1'b0; tmo = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            out_ready = (int'($urandom_range(99)) < thr);
            if (!out_valid) dropped = 1'b1;
            if (in_ready) early = 1'b1;
            hs = out_valid & out_ready;
            b  = out_bit;
            l  = out_last;
            @(posedge clk); #1;
            if (hs) begin
                obs = obs | (SW'(b) << n);
                if (l) last_pos = n;
                n++;
                if (l) begin
                    tmo = 1'b0;
                    break;
                end
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic verify(input string tag, input logic m, input int len, input logic [MAXB-1:0] d,
                          input logic [SW-1:0] obs, input int n, input int last_pos,
                          input logic dropped, input logic early, input logic tmo);
        logic [SW-1:0] exp;
        int            ne;
        int            w;
        model(m, len, d, exp, ne);
        w = m ? 16 : 5;
        check({tag, "_timeout"}, SW'(tmo), SW'(0));
        check({tag, "_bits"}, obs, exp);
        check({tag, "_count"}, SW'(n), SW'(ne));
        check({tag, "_last_pos"}, SW'(last_pos), SW'(ne - 1));
        check({tag, "_valid_held"}, SW'(dropped), SW'(0));
        check({tag, "_no_early_ready"}, SW'(early), SW'(0));
        check({tag, "_residual"}, SW'(resid(obs, n, w)), m ? SW'(16'h800D) : SW'(5'b01100));
        check({tag, "_ready_after"}, SW'({in_ready, busy, out_valid}), SW'(3'b100));
`ifdef USB_CRC_SELFCHECK_EN
        check({tag, "_crc_err"}, SW'(crc_err), SW'(0));
`endif
    endtask

    task automatic run_pkt(input string tag, input logic m, input int len, input logic [MAXB-1:0] d,
                           input int thr, output logic [SW-1:0] obs);
        int   n, lp;
        logic dr, ea, tm;
        accept(tag, m, len, d);
        in_valid = 1'b0;
        collect(thr, obs, n, lp, dr, ea, tm);
        verify(tag, m, len, d, obs, n, lp, dr, ea, tm);
    endtask

    initial begin
        logic [SW-1:0]   s1, s2;
        logic [MAXB-1:0] d, db;
        int              ln, nn, lp;
        logic            dr, ea, tm;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", SW'({in_ready, busy, out_valid, out_bit, out_last}), SW'(5'b10000));
`ifdef USB_CRC_SELFCHECK_EN
        check("reset_crc_err", SW'(crc_err), SW'(0));
`endif
        rst_b = 1'b1;
        @(posedge clk); #1;
        check("idle_after_release", SW'({in_ready, busy, out_valid, out_bit, out_last}), SW'(5'b10000));

        run_pkt("tok0", 1'b0, 11, '0, 100, s1);
        check("tok0_payload", SW'(s1[10:0]), SW'(0));
        check("tok0_crc_field", SW'(s1[15:11]), SW'(5'b00010));

        d = MAXB'(32'h03020100);
        run_pkt("data32", 1'b1, 32, d, 100, s1);

        run_pkt("len0", 1'b1, 0, rand_data(), 100, s1);
        check("len0_bits", SW'(s1[15:0]), SW'(0));

        run_pkt("tok_junk", 1'b0, 777, rand_data(), 100, s1);
        run_pkt("clamp", 1'b1, 1000, rand_data(), 100, s1);

        d = rand_data();
        run_pkt("pkt64_full", 1'b1, 512, d, 100, s1);
        run_pkt("pkt64_thr", 1'b1, 512, d, 50, s2);
        check("pkt64_same_stream", s2, s1);

        for (int t = 0; t < 6; t++) begin
            ln = int'($urandom_range(1023));
            run_pkt($sformatf("rnd%0d", t), t[0], ln, rand_data(), 70, s1);
        end

        d  = rand_data();
        db = rand_data();
        accept("holdA", 1'b1, 40, d);
        in_mode = 1'b0;
        in_len  = LW'(5);
        in_data = db;
        collect(60, s1, nn, lp, dr, ea, tm);
        verify("holdA", 1'b1, 40, d, s1, nn, lp, dr, ea, tm);
        @(posedge clk); #1;
        check("holdB_accept", SW'({in_ready, busy, out_valid}), SW'(3'b011));
        in_valid = 1'b0;
        collect(100, s1, nn, lp, dr, ea, tm);
        verify("holdB", 1'b0, 5, db, s1, nn, lp, dr, ea, tm);

        d = rand_data();
        accept("rstA", 1'b1, 64, d);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("rst_pre_bit20", SW'({out_valid, out_bit}), SW'({1'b1, d[20]}));
        #2;
        rst_b = 1'b0;
        #1;
        check("rst_async", SW'({in_ready, busy, out_valid, out_bit, out_last}), SW'(5'b10000));
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_release_idle", SW'({in_ready, busy, out_valid, out_bit, out_last}), SW'(5'b10000));
        run_pkt("tok_after_rst", 1'b0, 11, rand_data(), 100, s1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
